sprite_renderer: RTL and testbench
==================================

SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 SHALL have parameter SPR_W, 65: sprite width in texels.
REQ-002 SHALL have parameter SPR_H, 120: sprite height in texels.
REQ-003 SHALL have parameter FRAMES, 4: animation frames stored back-to-back in ROM.
REQ-004 SHALL have parameter SCALE_LOG2, 0: on-screen magnification 2^SCALE_LOG2 (legal 0..2).
REQ-005 SHALL have parameter HOLD, 6: display frames per animation step (legal 1..255).
REQ-006 SHALL have parameter TRANSP_IDX, 0: palette index treated as transparent.
REQ-007 SHALL have parameter ADDR_W, 15: ROM address width, >= clog2(SPR_W*SPR_H*FRAMES).
REQ-008 SHALL have ports:
  vga_clk      in   1       pixel clock; all state on posedge
  reset_n      in   1       synchronous reset, active-low
  DrawX        in   10      current pixel column
  DrawY        in   10      current pixel row
  blank        in   1       1 = active video, 0 = blanking
  frame_start  in   1       one-cycle pulse at start of each display frame
  pos_x        in   10      sprite left edge, screen pixels
  pos_y        in   10      sprite top edge, screen pixels
  flip_h       in   1       1 = mirror sprite horizontally
  anim_en      in   1       1 = animation advances
  anim_restart in   1       pulse: force frame 0
  bg_red/bg_green/bg_blue  in 4 each  background colour for this pixel
  rom_address  out  ADDR_W  registered address to sprite ROM
  rom_q        in   4       ROM data, valid one cycle after rom_address
  pal_index    out  4       combinational copy of rom_q to external palette
  pal_red/pal_green/pal_blue  in 4 each  palette colour for pal_index (combinational)
  red/green/blue  out 4 each  registered pixel colour
  sprite_opaque   out 1       registered; 1 = output pixel came from sprite
  cur_frame       out clog2(FRAMES)  current animation frame

Function
REQ-009 SHALL capture pos_x, pos_y, flip_h into shadow registers only on cycles with frame_start=1; rendering uses shadow values exclusively (no mid-frame tearing).
REQ-010 SHALL compute hit = DrawX in [px, px+(SPR_W<<SCALE_LOG2)) and DrawY in [py, py+(SPR_H<<SCALE_LOG2)), using 11-bit sums so edges past 639/479 clip, never wrap.
REQ-011 SHALL form lx=(DrawX-px)>>SCALE_LOG2, ly=(DrawY-py)>>SCALE_LOG2; rx = flip ? SPR_W-1-lx : lx.
REQ-012 SHALL form address = cur_frame*SPR_W*SPR_H + ly*SPR_W + rx, truncated to ADDR_W; when hit=0 address is don't-care but registered value SHALL be 0.
REQ-013 Pipeline, fixed latency 3 cycles from DrawX/DrawY/blank/bg_* sample to red/green/blue: S1 registers rom_address, hit, blank, bg_*; S2 (ROM read) delays hit, blank, bg_*; S3 registers output.
REQ-014 S3: blank_d=0 -> rgb=0, sprite_opaque=0; else hit_d=1 and rom_q!=TRANSP_IDX -> rgb=pal_*, sprite_opaque=1; else rgb=bg_*, sprite_opaque=0.
REQ-015 Animation: hold counter increments on frame_start when anim_en=1; on reaching HOLD it clears and cur_frame increments, FRAMES-1 wraps to 0.
REQ-016 anim_en=0: hold counter and cur_frame frozen.
REQ-017 anim_restart=1 SHALL clear cur_frame and hold counter next cycle, overriding a simultaneous frame_start advance.
REQ-018 cur_frame change SHALL take effect only at frame_start (updated together with shadow registers), except anim_restart which is immediate.

Reset
REQ-019 reset_n=0 at a posedge SHALL clear rom_address, red, green, blue, sprite_opaque, cur_frame, hold counter, shadow pos/flip, all pipeline flags, next cycle, regardless of pipeline content.
REQ-020 First valid output after reset_n returns high SHALL appear 3 cycles after the first sampled pixel; prior outputs stay 0.

Verification
REQ-021 pos=(100,50), SCALE_LOG2=0, frame 0, blank=1, DrawX=100,DrawY=50 -> rom_address=0 after 1 cycle; rgb=pal_* after 3 cycles if rom_q=5.
REQ-022 Same, flip_h=1 latched, DrawX=100 -> rom_address=64; DrawX=164 -> 0; DrawX=165 -> hit=0, rgb=bg_*.
REQ-023 rom_q=TRANSP_IDX on hit pixel -> rgb=bg_*, sprite_opaque=0; blank=0 -> rgb=0.
REQ-024 HOLD=6, anim_en=1, 24 frame_start pulses -> cur_frame 0,1,2,3 then wraps to 0; anim_restart with frame_start same cycle -> cur_frame=0.
REQ-025 pos_x=600, SCALE_LOG2=1 -> DrawX 639 hits (lx=19), no wrap hit at DrawX 0..5; pos_x change mid-frame ignored until next frame_start.
REQ-026 reset_n=0 mid-line with opaque pixels in flight -> all outputs 0 next cycle, cur_frame=0.

Source files
------------

// File: rtl/sprite_renderer.sv
// sprite_renderer: overlays one animated, optionally mirrored and magnified
// sprite onto a VGA pixel stream. Three-cycle pipeline: address/hit (S1),
// external ROM read (S2), colour select (S3). Sprite position, mirroring and
// animation frame only change at frame_start, so a frame never tears.
module sprite_renderer #(
   parameter int SPR_W      = 65,
   parameter int SPR_H      = 120,
   parameter int FRAMES     = 4,
   parameter int SCALE_LOG2 = 0,
   parameter int HOLD       = 6,
   parameter int TRANSP_IDX = 0,
   parameter int ADDR_W     = 15,
   localparam int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               blank,
   input  logic               frame_start,
   input  logic [9:0]         pos_x,
   input  logic [9:0]         pos_y,
   input  logic               flip_h,
   input  logic               anim_en,
   input  logic               anim_restart,
   input  logic [3:0]         bg_red,
   input  logic [3:0]         bg_green,
   input  logic [3:0]         bg_blue,
   output logic [ADDR_W-1:0]  rom_address,
   input  logic [3:0]         rom_q,
   output logic [3:0]         pal_index,
   input  logic [3:0]         pal_red,
   input  logic [3:0]         pal_green,
   input  logic [3:0]         pal_blue,
   output logic [3:0]         red,
   output logic [3:0]         green,
   output logic [3:0]         blue,
   output logic               sprite_opaque,
   output logic [FRAME_W-1:0] cur_frame
);

   // Frame-stable copies of the sprite placement
   logic [9:0]         shadow_x;
   logic [9:0]         shadow_y;
   logic               shadow_flip;
   // Animation state
   logic [7:0]         hold_cnt;
   logic [FRAME_W-1:0] frame_q;

   // Combinational S1 results
   logic [10:0]        x_end;
   logic [10:0]        y_end;
   logic               hit;
   logic [9:0]         lx;
   logic [9:0]         ly;
   logic [9:0]         rx;
   logic [ADDR_W-1:0]  addr_next;

   // Pipeline flags and background colour travelling alongside the ROM read
   logic               s1_hit, s1_blank;
   logic [3:0]         s1_bg_r, s1_bg_g, s1_bg_b;
   logic               s2_hit, s2_blank;
   logic [3:0]         s2_bg_r, s2_bg_g, s2_bg_b;

   assign cur_frame = frame_q;
   assign pal_index = rom_q;

   // Hit test and texel address; 11-bit right edges clip past the screen rather than wrap
   always_comb begin
      x_end     = {1'b0, shadow_x} + 11'(SPR_W << SCALE_LOG2);
      y_end     = {1'b0, shadow_y} + 11'(SPR_H << SCALE_LOG2);
      hit       = (DrawX >= shadow_x) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= shadow_y) && ({1'b0, DrawY} < y_end);
      lx        = (DrawX - shadow_x) >> SCALE_LOG2;
      ly        = (DrawY - shadow_y) >> SCALE_LOG2;
      rx        = shadow_flip ? (10'(SPR_W - 1) - lx) : lx;
      addr_next = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H) +
                  ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(rx);
   end

   // Placement shadow registers, loaded only at the start of a display frame
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         shadow_x    <= '0;
         shadow_y    <= '0;
         shadow_flip <= 1'b0;
      end else if (frame_start) begin
         shadow_x    <= pos_x;
         shadow_y    <= pos_y;
         shadow_flip <= flip_h;
      end
   end

   // Animation: count frame_starts, step the frame every HOLD of them; restart wins
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hold_cnt <= '0;
         frame_q  <= '0;
      end else if (anim_restart) begin
         hold_cnt <= '0;
         frame_q  <= '0;
      end else if (frame_start && anim_en) begin
         if (hold_cnt == 8'(HOLD - 1)) begin
            hold_cnt <= '0;
            frame_q  <= (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
         end else begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end

   // S1: register ROM address (0 on a miss) and the per-pixel side information
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         rom_address <= '0;
         s1_hit      <= 1'b0;
         s1_blank    <= 1'b0;
         s1_bg_r     <= '0;
         s1_bg_g     <= '0;
         s1_bg_b     <= '0;
      end else begin
         rom_address <= hit ? addr_next : '0;
         s1_hit      <= hit;
         s1_blank    <= blank;
         s1_bg_r     <= bg_red;
         s1_bg_g     <= bg_green;
         s1_bg_b     <= bg_blue;
      end
   end

   // S2: hold side information while the ROM produces rom_q
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         s2_hit   <= 1'b0;
         s2_blank <= 1'b0;
         s2_bg_r  <= '0;
         s2_bg_g  <= '0;
         s2_bg_b  <= '0;
      end else begin
         s2_hit   <= s1_hit;
         s2_blank <= s1_blank;
         s2_bg_r  <= s1_bg_r;
         s2_bg_g  <= s1_bg_g;
         s2_bg_b  <= s1_bg_b;
      end
   end

   // S3: choose black during blanking, sprite colour on an opaque hit, else background
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         red           <= '0;
         green         <= '0;
         blue          <= '0;
         sprite_opaque <= 1'b0;
      end else if (!s2_blank) begin
         red           <= '0;
         green         <= '0;
         blue          <= '0;
         sprite_opaque <= 1'b0;
      end else if (s2_hit && (rom_q != 4'(TRANSP_IDX))) begin
         red           <= pal_red;
         green         <= pal_green;
         blue          <= pal_blue;
         sprite_opaque <= 1'b1;
      end else begin
         red           <= s2_bg_r;
         green         <= s2_bg_g;
         blue          <= s2_bg_b;
         sprite_opaque <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: two instances (magnification 1x and 2x) share the
// stimulus; each has its own ROM read port onto one bench-owned texture array.
module tb_sprite_renderer;

   localparam int SPR_W = 65, SPR_H = 120, FRAMES = 4, HOLD = 6;
   localparam int TRANSP_IDX = 0, ADDR_W = 15;

   logic vga_clk = 1'b0;
   logic reset_n;
   logic [9:0] draw_x, draw_y, pos_x, pos_y;
   logic blank, frame_start, flip_h, anim_en, anim_restart;
   logic [3:0] bg_red, bg_green, bg_blue;

   logic [ADDR_W-1:0] rom_address_a, rom_address_b;
   logic [3:0] rom_q_a, rom_q_b, pal_index_a, pal_index_b;
   logic [3:0] pal_red_a, pal_green_a, pal_blue_a, pal_red_b, pal_green_b, pal_blue_b;
   logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
   logic sprite_opaque_a, sprite_opaque_b;
   logic [1:0] cur_frame_a, cur_frame_b;
   logic [12:0] out_a, out_b;

   logic [3:0] rom_mem [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;
   // Reference state: sprite placement and number of counted animation pulses
   int m_px, m_py, m_cnt;
   bit m_flip;

   assign out_a = {sprite_opaque_a, red_a, green_a, blue_a};
   assign out_b = {sprite_opaque_b, red_b, green_b, blue_b};

   function automatic logic [3:0] pal_r(input logic [3:0] v); return v ^ 4'hA; endfunction
   function automatic logic [3:0] pal_g(input logic [3:0] v); return ~v; endfunction
   function automatic logic [3:0] pal_b(input logic [3:0] v); return v + 4'd3; endfunction

   assign pal_red_a = pal_r(pal_index_a);
   assign pal_green_a = pal_g(pal_index_a);
   assign pal_blue_a = pal_b(pal_index_a);
   assign pal_red_b = pal_r(pal_index_b);
   assign pal_green_b = pal_g(pal_index_b);
   assign pal_blue_b = pal_b(pal_index_b);

   sprite_renderer dut_a (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
      .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
      .flip_h(flip_h), .anim_en(anim_en), .anim_restart(anim_restart),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .rom_address(rom_address_a), .rom_q(rom_q_a), .pal_index(pal_index_a),
      .pal_red(pal_red_a), .pal_green(pal_green_a), .pal_blue(pal_blue_a),
      .red(red_a), .green(green_a), .blue(blue_a),
      .sprite_opaque(sprite_opaque_a), .cur_frame(cur_frame_a));

   sprite_renderer #(.SCALE_LOG2(1)) dut_b (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
      .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
      .flip_h(flip_h), .anim_en(anim_en), .anim_restart(anim_restart),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .rom_address(rom_address_b), .rom_q(rom_q_b), .pal_index(pal_index_b),
      .pal_red(pal_red_b), .pal_green(pal_green_b), .pal_blue(pal_blue_b),
      .red(red_b), .green(green_b), .blue(blue_b),
      .sprite_opaque(sprite_opaque_b), .cur_frame(cur_frame_b));

   // Clock
   always #5 vga_clk = ~vga_clk;

   // Synchronous sprite ROMs: data one cycle after the address
   always @(posedge vga_clk) begin
      rom_q_a <= rom_mem[rom_address_a];
      rom_q_b <= rom_mem[rom_address_b];
   end

   function automatic int m_frame();
      return (m_cnt / HOLD) % FRAMES;
   endfunction

   // Where on the sprite a screen pixel lands, from the placement rules
   function automatic void model_px(input int scale, input int x, input int y,
                                    output int addr, output bit hit);
      int lx, ly, rx;
      hit = (x >= m_px) && (x < m_px + (SPR_W << scale)) &&
            (y >= m_py) && (y < m_py + (SPR_H << scale));
      addr = 0;
      if (hit) begin
         lx = (x - m_px) >> scale;
         ly = (y - m_py) >> scale;
         rx = m_flip ? (SPR_W - 1 - lx) : lx;
         addr = (m_frame() * SPR_W * SPR_H + ly * SPR_W + rx) % (1 << ADDR_W);
      end
   endfunction

   // Expected {opaque, r, g, b} for one pixel
   function automatic logic [12:0] exp_pix(input int scale, input int x, input int y, input bit b,
                                           input logic [3:0] r, input logic [3:0] g,
                                           input logic [3:0] bl);
      int a;
      bit h;
      logic [3:0] v;
      if (!b) return 13'd0;
      model_px(scale, x, y, a, h);
      v = rom_mem[a];
      if (h && v != 4'(TRANSP_IDX)) return {1'b1, pal_r(v), pal_g(v), pal_b(v)};
      return {1'b0, r, g, bl};
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic drive_px(input int x, input int y, input bit b);
      draw_x = 10'(x);
      draw_y = 10'(y);
      blank = b;
      bg_red = 4'($urandom_range(0, 15));
      bg_green = 4'($urandom_range(0, 15));
      bg_blue = 4'($urandom_range(0, 15));
   endtask

   task automatic do_frame_start(input int px, input int py, input bit flip);
      pos_x = 10'(px);
      pos_y = 10'(py);
      flip_h = flip;
      frame_start = 1'b1;
      blank = 1'b0;
      tick();
      frame_start = 1'b0;
      m_px = px;
      m_py = py;
      m_flip = flip;
      if (anim_restart) m_cnt = 0;
      else if (anim_en) m_cnt++;
   endtask

   task automatic test_reset();
      logic [12:0] e;
      reset_n = 1'b0;
      anim_en = 1'b0;
      anim_restart = 1'b0;
      frame_start = 1'b0;
      pos_x = 10'd0;
      pos_y = 10'd0;
      flip_h = 1'b0;
      drive_px(0, 0, 1'b1);
      tick();
      tick();
      checks++;
      if (out_a !== 13'd0 || out_b !== 13'd0) begin
         errors++;
         $display("FAIL reset_rgb: got %h/%h expected 0", out_a, out_b);
      end
      checks++;
      if (rom_address_a !== '0 || cur_frame_a !== 2'd0) begin
         errors++;
         $display("FAIL reset_addr_frame: got %0d/%0d expected 0/0", rom_address_a, cur_frame_a);
      end
      m_px = 0; m_py = 0; m_flip = 0; m_cnt = 0;
      reset_n = 1'b1;
      drive_px(0, 0, 1'b1);
      e = exp_pix(0, 0, 0, 1'b1, bg_red, bg_green, bg_blue);
      tick();
      checks++;
      if (out_a !== 13'd0) begin
         errors++;
         $display("FAIL first_out_c1: got %h expected 0", out_a);
      end
      tick();
      checks++;
      if (out_a !== 13'd0) begin
         errors++;
         $display("FAIL first_out_c2: got %h expected 0", out_a);
      end
      tick();
      checks++;
      if (out_a !== e) begin
         errors++;
         $display("FAIL first_out_c3: got %h expected %h", out_a, e);
      end
   endtask

   task automatic test_basic();
      int a, x, y;
      bit h;
      logic [12:0] e;
      do_frame_start(100, 50, 1'b0);
      for (int k = 0; k < 4; k++) begin
         x = (k == 0) ? 100 : 100 + $urandom_range(0, 64);
         y = (k == 0) ? 50 : 50 + $urandom_range(0, 119);
         drive_px(x, y, 1'b1);
         model_px(0, x, y, a, h);
         e = exp_pix(0, x, y, 1'b1, bg_red, bg_green, bg_blue);
         tick();
         checks++;
         if (rom_address_a !== ADDR_W'(a) || (k == 0 && rom_address_a !== '0)) begin
            errors++;
            $display("FAIL basic_addr (%0d,%0d): got %0d expected %0d", x, y, rom_address_a, a);
         end
         tick();
         tick();
         checks++;
         if (out_a !== e) begin
            errors++;
            $display("FAIL basic_rgb (%0d,%0d): got %h expected %h", x, y, out_a, e);
         end
      end
   endtask

   task automatic test_flip();
      int xs[3] = '{100, 164, 165};
      int ea[3] = '{64, 0, 0};
      logic [12:0] e;
      do_frame_start(100, 50, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive_px(xs[k], 50, 1'b1);
         e = exp_pix(0, xs[k], 50, 1'b1, bg_red, bg_green, bg_blue);
         tick();
         checks++;
         if (rom_address_a !== ADDR_W'(ea[k])) begin
            errors++;
            $display("FAIL flip_addr x=%0d: got %0d expected %0d", xs[k], rom_address_a, ea[k]);
         end
         tick();
         tick();
         checks++;
         if (out_a !== e || (k == 2 && out_a !== {1'b0, bg_red, bg_green, bg_blue})) begin
            errors++;
            $display("FAIL flip_rgb x=%0d: got %h expected %h", xs[k], out_a, e);
         end
      end
   endtask

   task automatic test_transparent();
      do_frame_start(100, 50, 1'b0);
      rom_mem[1] = 4'(TRANSP_IDX);
      drive_px(101, 50, 1'b1);
      tick();
      tick();
      tick();
      checks++;
      if (out_a !== {1'b0, bg_red, bg_green, bg_blue}) begin
         errors++;
         $display("FAIL transp_rgb: got %h expected %h", out_a, {1'b0, bg_red, bg_green, bg_blue});
      end
      drive_px(100, 50, 1'b0);
      tick();
      tick();
      tick();
      checks++;
      if (out_a !== 13'd0) begin
         errors++;
         $display("FAIL blank_rgb: got %h expected 0", out_a);
      end
   endtask

   task automatic test_anim();
      anim_en = 1'b1;
      anim_restart = 1'b1;
      tick();
      anim_restart = 1'b0;
      m_cnt = 0;
      checks++;
      if (cur_frame_a !== 2'd0) begin
         errors++;
         $display("FAIL anim_restart_idle: got %0d expected 0", cur_frame_a);
      end
      for (int i = 1; i <= 24; i++) begin
         do_frame_start(100, 50, 1'b0);
         checks++;
         if (cur_frame_a !== 2'((i / HOLD) % FRAMES)) begin
            errors++;
            $display("FAIL anim_step pulse %0d: got %0d expected %0d", i, cur_frame_a, (i / HOLD) % FRAMES);
         end
      end
      // Frozen with anim_en low
      for (int i = 0; i < 7; i++) do_frame_start(100, 50, 1'b0);
      anim_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         do_frame_start(100, 50, 1'b0);
         checks++;
         if (cur_frame_a !== 2'(m_frame()) || cur_frame_a !== 2'd1) begin
            errors++;
            $display("FAIL anim_frozen: got %0d expected 1", cur_frame_a);
         end
      end
      anim_en = 1'b1;
      // Restart together with a frame_start
      anim_restart = 1'b1;
      do_frame_start(100, 50, 1'b0);
      anim_restart = 1'b0;
      checks++;
      if (cur_frame_a !== 2'd0) begin
         errors++;
         $display("FAIL anim_restart_fs: got %0d expected 0", cur_frame_a);
      end
      for (int i = 1; i <= HOLD; i++) begin
         do_frame_start(100, 50, 1'b0);
         checks++;
         if (cur_frame_a !== 2'(i / HOLD)) begin
            errors++;
            $display("FAIL anim_after_restart pulse %0d: got %0d expected %0d", i, cur_frame_a, i / HOLD);
         end
      end
      anim_restart = 1'b1;
      tick();
      anim_restart = 1'b0;
      m_cnt = 0;
      checks++;
      if (cur_frame_a !== 2'd0) begin
         errors++;
         $display("FAIL anim_restart_now: got %0d expected 0", cur_frame_a);
      end
   endtask

   task automatic test_clip();
      int a;
      bit h;
      logic [12:0] e;
      do_frame_start(600, 50, 1'b0);
      drive_px(639, 60, 1'b1);
      model_px(1, 639, 60, a, h);
      e = exp_pix(1, 639, 60, 1'b1, bg_red, bg_green, bg_blue);
      tick();
      checks++;
      if (rom_address_b !== ADDR_W'(a) || a != m_frame() * SPR_W * SPR_H + 5 * SPR_W + 19) begin
         errors++;
         $display("FAIL clip_edge_addr: got %0d expected %0d", rom_address_b, a);
      end
      tick();
      tick();
      checks++;
      if (out_b !== e) begin
         errors++;
         $display("FAIL clip_edge_rgb: got %h expected %h", out_b, e);
      end
      for (int x = 0; x <= 5; x++) begin
         drive_px(x, 60, 1'b1);
         tick();
         checks++;
         if (rom_address_b !== '0) begin
            errors++;
            $display("FAIL clip_nowrap x=%0d: got %0d expected 0", x, rom_address_b);
         end
      end
      // Position change without frame_start must not move the sprite
      pos_x = 10'd0;
      drive_px(2, 60, 1'b1);
      tick();
      tick();
      checks++;
      if (rom_address_b !== '0) begin
         errors++;
         $display("FAIL midframe_pos: got %0d expected 0", rom_address_b);
      end
      do_frame_start(0, 50, 1'b0);
      drive_px(2, 60, 1'b1);
      model_px(1, 2, 60, a, h);
      tick();
      checks++;
      if (rom_address_b !== ADDR_W'(a) || !h) begin
         errors++;
         $display("FAIL newframe_pos: got %0d expected %0d", rom_address_b, a);
      end
   endtask

   task automatic test_random();
      logic [12:0] q_a[$];
      logic [12:0] q_b[$];
      logic [12:0] e;
      int a0, a1, x, y;
      bit h, b, fs;
      for (int i = 0; i < 600; i++) begin
         fs = (i % 40 == 0) && (i < 598);
         if (fs) begin
            pos_x = 10'($urandom_range(0, 639));
            pos_y = 10'($urandom_range(0, 479));
            flip_h = 1'($urandom_range(0, 1));
            anim_en = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 7) == 0) begin
            pos_x = 10'($urandom_range(0, 1023));
            pos_y = 10'($urandom_range(0, 1023));
            flip_h = 1'($urandom_range(0, 1));
         end
         x = int'((m_px + $urandom_range(0, 150) - 10) & 1023);
         y = int'((m_py + $urandom_range(0, 260) - 10) & 1023);
         b = (i < 598) && ($urandom_range(0, 7) != 0);
         drive_px(x, y, b);
         frame_start = fs;
         q_a.push_back(exp_pix(0, x, y, b, bg_red, bg_green, bg_blue));
         q_b.push_back(exp_pix(1, x, y, b, bg_red, bg_green, bg_blue));
         model_px(0, x, y, a0, h);
         model_px(1, x, y, a1, h);
         tick();
         frame_start = 1'b0;
         if (fs) begin
            m_px = int'(pos_x);
            m_py = int'(pos_y);
            m_flip = flip_h;
            if (anim_en) m_cnt++;
         end
         checks++;
         if (rom_address_a !== ADDR_W'(a0) || rom_address_b !== ADDR_W'(a1)) begin
            errors++;
            $display("FAIL rand_addr i=%0d: got %0d/%0d expected %0d/%0d", i, rom_address_a, rom_address_b, a0, a1);
         end
         checks++;
         if (cur_frame_a !== 2'(m_frame()) || cur_frame_b !== 2'(m_frame())) begin
            errors++;
            $display("FAIL rand_frame i=%0d: got %0d/%0d expected %0d", i, cur_frame_a, cur_frame_b, m_frame());
         end
         if (q_a.size() == 3) begin
            e = q_a.pop_front();
            checks++;
            if (out_a !== e) begin
               errors++;
               $display("FAIL rand_rgb_1x i=%0d: got %h expected %h", i, out_a, e);
            end
            e = q_b.pop_front();
            checks++;
            if (out_b !== e) begin
               errors++;
               $display("FAIL rand_rgb_2x i=%0d: got %h expected %h", i, out_b, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int a;
      bit h;
      anim_en = 1'b1;
      do_frame_start(10, 10, 1'b0);
      for (int k = 0; k < 12 && m_frame() == 0; k++) do_frame_start(10, 10, 1'b0);
      for (int i = 0; i < 4; i++) rom_mem[m_frame() * SPR_W * SPR_H + i] = 4'd7;
      for (int i = 0; i < 4; i++) begin
         drive_px(10 + i, 10, 1'b1);
         tick();
      end
      reset_n = 1'b0;
      tick();
      checks++;
      if (out_a !== 13'd0 || out_b !== 13'd0) begin
         errors++;
         $display("FAIL midreset_rgb: got %h/%h expected 0", out_a, out_b);
      end
      checks++;
      if (rom_address_a !== '0 || cur_frame_a !== 2'd0 || cur_frame_b !== 2'd0) begin
         errors++;
         $display("FAIL midreset_state: got addr %0d frame %0d/%0d expected 0", rom_address_a, cur_frame_a, cur_frame_b);
      end
      reset_n = 1'b1;
      m_px = 0; m_py = 0; m_flip = 0; m_cnt = 0;
      pos_x = 10'd200;
      pos_y = 10'd200;
      drive_px(3, 2, 1'b1);
      model_px(0, 3, 2, a, h);
      tick();
      checks++;
      if (rom_address_a !== ADDR_W'(a) || a != 2 * SPR_W + 3) begin
         errors++;
         $display("FAIL midreset_shadow: got %0d expected %0d", rom_address_a, 2 * SPR_W + 3);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'($urandom_range(0, 15));
      rom_mem[0] = 4'd5;
      test_reset();
      test_basic();
      test_flip();
      test_transparent();
      test_anim();
      test_clip();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
